// File: rtl/dfi_rd_gather.sv
// Per-channel read-return gatherer: packs PHY beats into MMC words, buffers them in a FIFO, tracks outstanding reads.
// Optional idle timeout recovery is enabled by defining DFI_RD_GATHER_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | no partial word held, next accepted beat is beat 0
// ST_GATHER | partial word in progress, waiting for remaining beats
module dfi_rd_gather #(
    parameter int NUM_CHANNELS   = 2,
    parameter int BEAT_WIDTH     = 32,
    parameter int BEATS_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int OUTST_W        = 4,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                                          clk,
    input  logic                                          reset_poweron,
    input  logic [NUM_CHANNELS-1:0]                       mmc__dfi__rd_issue,
    input  logic [NUM_CHANNELS-1:0]                       phy__dfi__data_valid,
    input  logic [NUM_CHANNELS*BEAT_WIDTH-1:0]            phy__dfi__data,
    output logic [NUM_CHANNELS-1:0]                       dfi__mmc__valid,
    output logic [NUM_CHANNELS*BEAT_WIDTH*BEATS_PER_WORD-1:0] dfi__mmc__data,
    input  logic [NUM_CHANNELS-1:0]                       mmc__dfi__ready,
    output logic [NUM_CHANNELS*OUTST_W-1:0]               dfi__mmc__outstanding,
    output logic [3*NUM_CHANNELS-1:0]                     dfi__mmc__err,
    input  logic                                          mmc__dfi__clr_err
);

    localparam int WORD_W = BEAT_WIDTH * BEATS_PER_WORD;
    localparam int CNT_W  = $clog2(BEATS_PER_WORD);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS_PER_WORD - 1);
    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    typedef enum logic {ST_IDLE, ST_GATHER} state_t;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        state_t                r_state, w_state_nxt;
        logic [CNT_W-1:0]      r_beat_cnt;
        logic [WORD_W-1:0]     r_word, w_word_now;
        logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
        logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;
        logic [OUTST_W-1:0]    r_outst;
        logic [2:0]            r_err;
        logic [BEAT_WIDTH-1:0] w_beat;
        logic w_valid_in, w_accept, w_unexp, w_last, w_empty, w_full;
        logic w_pop, w_push, w_ovf, w_issue, w_dec, w_sat, w_timeout;

        assign w_beat     = phy__dfi__data[c*BEAT_WIDTH +: BEAT_WIDTH];
        assign w_valid_in = phy__dfi__data_valid[c];
        assign w_issue    = mmc__dfi__rd_issue[c];
        assign w_accept   = w_valid_in && (r_outst != '0);
        assign w_unexp    = w_valid_in && (r_outst == '0);
        assign w_last     = w_accept && (r_beat_cnt == LAST_BEAT);
        assign w_empty    = (r_wr_ptr == r_rd_ptr);
        assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                            (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
        assign w_pop      = !w_empty && mmc__dfi__ready[c];
        // A full FIFO still takes the new word when the head leaves in the same cycle.
        assign w_push     = w_last && (!w_full || w_pop);
        assign w_ovf      = w_last && w_full && !w_pop;
        assign w_dec      = w_last || w_timeout;
        assign w_sat      = w_issue && !w_dec && (r_outst == OUTST_MAX);

`ifdef DFI_RD_GATHER_TIMEOUT_EN
        localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [IDLE_W-1:0] r_idle;
        logic              w_idle_cnt;

        assign w_idle_cnt = (r_outst != '0) && !w_valid_in;
        assign w_timeout  = w_idle_cnt && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk or negedge reset_poweron) begin
            if (!reset_poweron) begin
                r_idle <= '0;
            end else if (!w_idle_cnt || w_timeout) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
`else
        assign w_timeout = 1'b0;
`endif

        always_comb begin
            w_word_now = r_word;
            for (int k = 0; k < BEATS_PER_WORD; k++) begin
                if (r_beat_cnt == CNT_W'(k)) begin
                    w_word_now[k*BEAT_WIDTH +: BEAT_WIDTH] = w_beat;
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_IDLE:   if (w_accept) w_state_nxt = ST_GATHER;
                ST_GATHER: if (w_last || w_timeout) w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset_poweron) begin
            if (!reset_poweron) begin
                r_state    <= ST_IDLE;
                r_beat_cnt <= '0;
                r_word     <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_outst    <= '0;
                r_err      <= '0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end else begin
                r_state <= w_state_nxt;
                if (w_timeout) begin
                    r_beat_cnt <= '0;
                    r_word     <= '0;
                end else if (w_accept) begin
                    r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
                    r_word     <= w_last ? '0 : w_word_now;
                end
                if (w_push) begin
                    r_mem[r_wr_ptr[PTR_W-1:0]] <= w_word_now;
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_dec && !w_issue) begin
                    r_outst <= r_outst - 1'b1;
                end else if (w_issue && !w_dec && (r_outst != OUTST_MAX)) begin
                    r_outst <= r_outst + 1'b1;
                end
                r_err <= (mmc__dfi__clr_err ? 3'b000 : r_err) |
                         {w_timeout, (w_unexp || w_sat), w_ovf};
            end
        end

        assign dfi__mmc__valid[c]                          = !w_empty;
        assign dfi__mmc__data[c*WORD_W +: WORD_W]          = r_mem[r_rd_ptr[PTR_W-1:0]];
        assign dfi__mmc__outstanding[c*OUTST_W +: OUTST_W] = r_outst;
        assign dfi__mmc__err[c*3 +: 3]                     = r_err;
    end

endmodule

// File: tb/tb_dfi_rd_gather.sv
// Directed bench for dfi_rd_gather with default parameters (2 ch, 4x32-bit beats, 4-deep FIFO).
module tb_dfi_rd_gather;

    localparam int NC = 2;
    localparam int BW = 32;
    localparam int WW = 128;
    localparam int OW = 4;

    logic              clk;
    logic              reset_poweron;
    logic [NC-1:0]     rd_issue;
    logic [NC-1:0]     d_valid;
    logic [NC*BW-1:0]  d_data;
    logic [NC-1:0]     o_valid;
    logic [NC*WW-1:0]  o_data;
    logic [NC-1:0]     ready;
    logic [NC*OW-1:0]  o_outst;
    logic [3*NC-1:0]   o_err;
    logic              clr_err;

    int n_assert = 0;
    int n_fail   = 0;

    dfi_rd_gather dut (
        .clk                   (clk),
        .reset_poweron         (reset_poweron),
        .mmc__dfi__rd_issue    (rd_issue),
        .phy__dfi__data_valid  (d_valid),
        .phy__dfi__data        (d_data),
        .dfi__mmc__valid       (o_valid),
        .dfi__mmc__data        (o_data),
        .mmc__dfi__ready       (ready),
        .dfi__mmc__outstanding (o_outst),
        .dfi__mmc__err         (o_err),
        .mmc__dfi__clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            rd_issue[c] = 1'b1;
            tick();
        end
        rd_issue[c] = 1'b0;
    endtask

    task automatic send_word(input int c, input logic [WW-1:0] w, input bit ready_on_last);
        for (int k = 0; k < 4; k++) begin
            d_valid[c] = 1'b1;
            d_data[c*BW +: BW] = w[k*BW +: BW];
            if (k == 3 && ready_on_last) ready[c] = 1'b1;
            tick();
        end
        d_valid[c] = 1'b0;
        if (ready_on_last) ready[c] = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    function automatic logic [WW-1:0] mk(input int w);
        logic [WW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*BW +: BW] = 32'hC000_0000 | (w << 8) | k;
        return r;
    endfunction

    logic [WW-1:0] w1, w2, w3, w4;

    initial begin
        w1 = 128'h44444444_33333333_22222222_11111111;
        w2 = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
        w3 = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
        w4 = 128'h87654321_0FEDCBA9_13579BDF_2468ACE0;
        reset_poweron = 1'b0;
        rd_issue = '0; d_valid = '0; d_data = '0; ready = '0; clr_err = 1'b0;
        tick(); tick();
        chk("reset_valid", o_valid, 0);
        chk("reset_data",  o_data,  0);
        chk("reset_outst", o_outst, 0);
        chk("reset_err",   o_err,   0);
        reset_poweron = 1'b1;
        tick();

        // single read on ch0
        ready = 2'b11;
        issue(0, 1);
        chk("t1_outst_issued", o_outst[3:0], 1);
        send_word(0, w1, 1'b0);
        chk("t1_valid",     o_valid[0], 1);
        chk("t1_data",      o_data[0 +: WW], w1);
        chk("t1_outst_done", o_outst[3:0], 0);
        tick();
        chk("t1_popped", o_valid[0], 0);

        // unexpected beat on ch0
        d_valid[0] = 1'b1; d_data[0 +: BW] = 32'hDEAD_BEEF;
        tick();
        d_valid[0] = 1'b0;
        chk("t2_err_unexp", o_err[2:0], 3'b010);
        chk("t2_no_word",   o_valid[0], 0);
        pulse_clr();
        chk("t2_err_clr", o_err[2:0], 3'b000);
        issue(0, 1);
        send_word(0, w2, 1'b0);
        chk("t2_clean_word", o_data[0 +: WW], w2);
        tick();

        // back-pressure on ch1: 5 words into a 4-deep FIFO
        ready[1] = 1'b0;
        issue(1, 5);
        chk("t3_outst5", o_outst[7:4], 5);
        for (int w = 0; w < 5; w++) send_word(1, mk(w), 1'b0);
        chk("t3_valid",   o_valid[1], 1);
        chk("t3_err_ovf", o_err[5:3], 3'b001);
        chk("t3_outst0",  o_outst[7:4], 0);
        chk("t3_head_held", o_data[WW +: WW], mk(0));
        ready[1] = 1'b1;
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("t3_drain%0d", w), o_data[WW +: WW], mk(w));
            tick();
        end
        chk("t3_empty", o_valid[1], 0);
        ready[1] = 1'b0;
        pulse_clr();
        chk("t3_err_clr", o_err[5:3], 3'b000);

        // full FIFO with simultaneous pop on the last beat
        issue(1, 5);
        for (int w = 8; w < 12; w++) send_word(1, mk(w), 1'b0);
        send_word(1, mk(12), 1'b1);
        chk("t4_no_ovf", o_err[5:3], 3'b000);
        chk("t4_head",   o_data[WW +: WW], mk(9));
        ready[1] = 1'b1;
        for (int w = 9; w < 13; w++) begin
            chk($sformatf("t4_drain%0d", w), o_data[WW +: WW], mk(w));
            chk($sformatf("t4_valid%0d", w), o_valid[1], 1);
            tick();
        end
        chk("t4_empty", o_valid[1], 0);
        ready[1] = 1'b0;

        // reset mid-gather
        d_valid[1] = 1'b1; d_data[BW +: BW] = 32'h5555_5555;
        tick();
        d_valid[1] = 1'b0;
        issue(1, 1);
        send_word(1, w3, 1'b0);
        issue(0, 1);
        for (int k = 0; k < 2; k++) begin
            d_valid[0] = 1'b1; d_data[0 +: BW] = 32'hBAD0_0000 | k;
            tick();
        end
        d_valid[0] = 1'b0;
        chk("t5_pre_valid", o_valid, 2'b10);
        chk("t5_pre_err",   o_err[5:3], 3'b010);
        #3 reset_poweron = 1'b0;
        #1;
        chk("t5_rst_valid", o_valid, 0);
        chk("t5_rst_data",  o_data, 0);
        chk("t5_rst_outst", o_outst, 0);
        chk("t5_rst_err",   o_err, 0);
        tick();
        reset_poweron = 1'b1;
        tick();
        ready = 2'b00;
        issue(0, 1);
        send_word(0, w4, 1'b0);
        chk("t5_fresh_valid", o_valid[0], 1);
        chk("t5_fresh_word",  o_data[0 +: WW], w4);

`ifdef DFI_RD_GATHER_TIMEOUT_EN
        ready = 2'b11;
        tick();
        issue(0, 1);
        d_valid[0] = 1'b1; d_data[0 +: BW] = 32'h7777_7777;
        tick();
        d_valid[0] = 1'b0;
        for (int i = 0; i < 62; i++) tick();
        chk("t6_no_to_yet", o_err[2], 0);
        tick();
        chk("t6_to_err",   o_err[2], 1);
        chk("t6_to_outst", o_outst[3:0], 0);
        chk("t6_to_noword", o_valid[0], 0);
        issue(0, 1);
        send_word(0, w1, 1'b0);
        chk("t6_after_word", o_data[0 +: WW], w1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dfi_rd_gather.md
Name: dfi_rd_gather

Overview:
- Multi-channel read-return gatherer between the DRAM PHY read path and the MMC, in the single `clk` domain.
- Per channel, it collects BEATS_PER_WORD narrow PHY beats into one MMC-width word and buffers completed words in a small FIFO.
- Words are delivered to the MMC with a valid/ready handshake.
- It tracks outstanding reads per channel and flags overflow and unexpected-beat errors; it is the generalised, back-pressured successor to the fixed two-beat read capture.

Parameters:
NUM_CHANNELS, 2, number of independent DRAM channels
BEAT_WIDTH, 32, PHY read beat width in bits
BEATS_PER_WORD, 4, beats per MMC word (>=2)
FIFO_DEPTH, 4, completed-word FIFO entries per channel (power of 2, >=2)
OUTST_W, 4, outstanding-read counter width per channel
TIMEOUT_CYCLES, 63, idle cycles before timeout (optional feature only)

Ports:
clk  input  1  block clock
reset_poweron  input  1  asynchronous, active-low reset
mmc__dfi__rd_issue  input  NUM_CHANNELS  per-channel pulse: one read command issued
phy__dfi__data_valid  input  NUM_CHANNELS  per-channel beat valid
phy__dfi__data  input  NUM_CHANNELS*BEAT_WIDTH  beats; channel c at bits [c*BEAT_WIDTH +: BEAT_WIDTH]
dfi__mmc__valid  output  NUM_CHANNELS  FIFO head valid per channel
dfi__mmc__data  output  NUM_CHANNELS*BEAT_WIDTH*BEATS_PER_WORD  FIFO head word per channel
mmc__dfi__ready  input  NUM_CHANNELS  MMC accepts head word
dfi__mmc__outstanding  output  NUM_CHANNELS*OUTST_W  reads issued but not yet fully gathered
dfi__mmc__err  output  3*NUM_CHANNELS  sticky per channel: [0] FIFO overflow, [1] unexpected beat, [2] timeout
mmc__dfi__clr_err  input  1  synchronous clear of all sticky error bits

Behaviour:
- Reset (reset_poweron=0, async) clears all state: beat counters=0, FIFOs empty, dfi__mmc__valid=0, dfi__mmc__data=0, outstanding=0, err=0, timeout counters=0.
- Each channel is independent. Per-channel two-state FSM:
  - IDLE (beat_cnt=0): beat accepted -> GATHER.
  - GATHER: last beat -> IDLE.
- Beat acceptance: data_valid=1 and outstanding>0.
  - Beat k (0-based) is written to word bits [k*BEAT_WIDTH +: BEAT_WIDTH]; beat 0 is LSB.
  - beat_cnt increments and wraps to 0 after BEATS_PER_WORD-1.
- Unexpected beat: data_valid=1 with outstanding=0 -> beat discarded, err[1] set, FSM unchanged.
- Word completion: the cycle the last beat is accepted, the assembled word (including that beat) is pushed into the FIFO and outstanding decrements.
- Push into a full FIFO:
  - With a simultaneous pop (valid&ready): push succeeds.
  - Otherwise: word dropped, err[0] set. Outstanding still decrements.
- Outputs and latency:
  - dfi__mmc__valid = FIFO not empty; dfi__mmc__data = FIFO head (registered storage, not combinational from PHY).
  - Last beat at cycle N -> valid visible at N+1.
  - Pop on valid&ready; head advances next cycle. Data is held stable while valid=1 and ready=0.
- Outstanding counter:
  - +1 on rd_issue, -1 on word completion; both in the same cycle -> unchanged.
  - Saturates at 2^OUTST_W-1; an rd_issue at saturation sets err[1].
  - Never underflows, because beats are not accepted at 0.
- mmc__dfi__clr_err=1 clears err bits next cycle. A same-cycle new error wins (bit stays set).
- FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

Optional Feature:
- Macro: DFI_RD_GATHER_TIMEOUT_EN.
- Defined: per-channel idle counter.
  - Counts cycles with outstanding>0 and no data_valid; resets to 0 on any beat or when outstanding=0.
  - On reaching TIMEOUT_CYCLES: err[2] set, partial word discarded, beat_cnt=0, FSM->IDLE, outstanding decrements by 1, idle counter restarts.
- Undefined: no counter logic; err[2] tied 0; a lost beat stalls the channel until reset.

Test Plan:
- One read, ch0: rd_issue; beats 0x11111111,0x22222222,0x33333333,0x44444444 on consecutive cycles, ready=1 -> valid one cycle after beat 4, data=0x44444444_33333333_22222222_11111111, outstanding 1->0.
- Back-pressure: ready=0; issue 5 reads, ch1, FIFO_DEPTH=4 -> 4 words held in order, 5th dropped, err[0] of ch1 set. Then ready=1 -> 4 words drain in order; clr_err clears err[0].
- Full FIFO with simultaneous pop: FIFO full, ready=1 in the same cycle as the last beat -> no overflow, occupancy stays 4.
- Unexpected beat: data_valid=1 on ch0 with outstanding=0 -> err[1] set, no word produced, beat_cnt stays 0.
- Reset mid-gather: after 2 of 4 beats, assert reset_poweron low asynchronously -> all outputs 0 immediately. After release, a fresh 4-beat read yields a correct word with no stale beats.
- With DFI_RD_GATHER_TIMEOUT_EN: issue a read, send 1 beat, then silence for 63 cycles -> err[2] set, outstanding 1->0, no word pushed. The next read gathers correctly.
